// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer
// APB-fed transmit FIFO feeding an LSB-first serialiser that emits one bit
// every DIV clocks, with a registered bit-rate strobe (iq_rate) for the I/Q
// modulator. Words are sent back to back with no idle cycles between them.
// Optional feature: define FIFO_TX_STATUS_EN to enable the APB STATUS read
// register at paddr 2. Without it, prdata is tied to zero.
module fifo_tx_serializer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 64,
  parameter int DIV         = 25,
  parameter int STROBE_POS  = 14,
  parameter int AFULL_LEVEL = 56
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [1:0]             paddr,
  input  logic [15:0]            pwdata,
  output logic [15:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic                   en_tx,
  output logic                   data_out,
  output logic                   iq_rate,
  output logic                   mem_state,
  output logic                   afull,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] DIV_LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] STROBE_START = CW'(STROBE_POS);
  localparam logic [BW-1:0] BIT_LAST     = BW'(WIDTH - 1);
  localparam logic [AW:0]   AFULL_LVL    = (AW + 1)'(AFULL_LEVEL);
  localparam logic [AW:0]   PTR_ONE      = (AW + 1)'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // APB decode
  logic access;
  logic data_wr;
  logic ctrl_wr;
  logic push;
  logic flush;
  logic clr_underrun;

  // FIFO storage and pointers (extra MSB is the wrap bit)
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             avail;

  // Serialiser state
  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    div_cnt;
  logic [CW-1:0]    div_cnt_nxt;
  logic [BW-1:0]    bit_idx;
  logic [BW-1:0]    bit_idx_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             pop;
  logic             underrun_set;
  logic             underrun;

  assign access       = psel & penable;
  assign data_wr      = access & pwrite & (paddr == 2'd0);
  assign ctrl_wr      = access & pwrite & (paddr == 2'd1);
  assign push         = data_wr & ~full;
  assign flush        = ctrl_wr & pwdata[0];
  assign clr_underrun = ctrl_wr & pwdata[1];

  // A DATA write into a full FIFO is dropped and flagged; paddr 3 is unmapped.
  assign pslverr = (data_wr & full) | (access & (paddr == 2'd3));
  assign pready  = 1'b1;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign level     = wr_ptr - rd_ptr;
  assign afull     = (level >= AFULL_LVL);
  assign mem_state = ~empty;

  // A flush in progress hides the remaining words from the serialiser, so a
  // word boundary that coincides with the flush does not pick up stale data.
  assign avail = ~empty & ~flush;

  // Word storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= pwdata[WIDTH-1:0];
    end
  end

  // Write/read pointers: push advances wr_ptr, pop advances rd_ptr, flush
  // discards everything queued by catching rd_ptr up to wr_ptr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Serialiser next-state: bit timing, word boundaries and back-to-back pops.
  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    pop          = 1'b0;
    underrun_set = 1'b0;
    case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (en_tx && avail) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr[AW-1:0]];
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (bit_idx == BIT_LAST) begin
            bit_idx_nxt = '0;
            if (en_tx && avail) begin
              // Next word loads on the same edge so the stream has no gap.
              pop       = 1'b1;
              shreg_nxt = mem[rd_ptr[AW-1:0]];
            end else begin
              // Running out of data while still enabled is an underrun.
              state_nxt    = IDLE;
              underrun_set = en_tx;
            end
          end else begin
            bit_idx_nxt = bit_idx + BW'(1);
          end
        end else begin
          div_cnt_nxt = div_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serialiser registers; iq_rate is computed from next-state values so the
  // registered strobe lines up exactly with the div_cnt window it marks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      iq_rate <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      iq_rate <= (state_nxt == SHIFT) && (div_cnt_nxt >= STROBE_START);
    end
  end

  // Sticky underrun flag; a new underrun wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

  assign data_out = (state == SHIFT) & shreg[bit_idx];

`ifdef FIFO_TX_STATUS_EN
  logic unused_bits;
  assign unused_bits = ^pwdata;

  // STATUS read mux; every other address reads back zero.
  always_comb begin
    prdata = '0;
    if (access && !pwrite && (paddr == 2'd2)) begin
      prdata = {underrun, afull, full, empty, 12'(level)};
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{pwdata, underrun};
  assign prdata      = '0;
`endif

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer
// Directed stimulus with a bit-level scoreboard: stimulus pushes the expected
// serial bits of every word that must be transmitted; a monitor pops one bit
// at each rising edge of iq_rate and compares it with data_out.
`timescale 1ns/1ps
module tb_fifo_tx_serializer;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 64;
  localparam int DIV         = 25;
  localparam int STROBE_POS  = 14;
  localparam int AFULL_LEVEL = 56;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite  = 1'b0;
  logic [1:0]    paddr   = 2'd0;
  logic [15:0]   pwdata  = 16'd0;
  logic [15:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          en_tx   = 1'b0;
  logic          data_out;
  logic          iq_rate;
  logic          mem_state;
  logic          afull;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nrise  = 0;
  int last_wr_cyc = 0;
  bit exp_q[$];
  int rise_q[$];

  logic        err;
  logic [15:0] rd;
  logic [7:0]  w;
  int          t0;

  fifo_tx_serializer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV),
    .STROBE_POS(STROBE_POS), .AFULL_LEVEL(AFULL_LEVEL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .en_tx(en_tx), .data_out(data_out), .iq_rate(iq_rate),
    .mem_state(mem_state), .afull(afull), .level(level)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one expected bit per strobe rise, strobe width per bit period.
  initial begin
    bit prev;
    int hi;
    bit e;
    prev = 1'b0;
    hi   = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        hi   = 0;
      end else begin
        if (iq_rate) begin
          hi++;
          if (!prev) begin
            rise_q.push_back(cyc);
            nrise++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_bit: got data_out=%0b, expected no transmission (cycle %0d)", data_out, cyc);
            end else begin
              e = exp_q.pop_front();
              check("serial_bit", data_out, e);
            end
          end
        end else begin
          if (prev) check("strobe_width", hi, DIV - STROBE_POS);
          hi = 0;
        end
        prev = iq_rate;
      end
    end
  end

  task automatic expect_word(input logic [7:0] wd);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(wd[i]);
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 e = pslverr;
    @(posedge clk); #1;
    last_wr_cyc = cyc;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until every expected bit has been seen, then until the serialiser idles.
  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({name, "_bits_left"}, exp_q.size(), 0);
    wait_cycles(DIV + 2);
    check({name, "_idle_data"}, data_out, 1'b0);
    check({name, "_idle_iq"}, iq_rate, 1'b0);
  endtask

  task automatic wait_rises(input string name, input int target);
    int k;
    k = 0;
    while (nrise < target && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_rise_timeout"}, (nrise >= target), 1'b1);
  endtask

  function automatic int first_rise();
    return (rise_q.size() > 0) ? rise_q[0] : -100000;
  endfunction

  function automatic int rise_span();
    return (rise_q.size() > 1) ? (rise_q[rise_q.size()-1] - rise_q[0]) : -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #35;
    check("rst_data_out", data_out, 1'b0);
    check("rst_iq_rate", iq_rate, 1'b0);
    check("rst_level", level, 0);
    check("rst_mem_state", mem_state, 1'b0);
    check("rst_afull", afull, 1'b0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_prdata", prdata, 16'h0000);
    check("rst_pready", pready, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_cycles(2);

    // Single word 0xA5, en_tx already high
    en_tx = 1'b1;
    rise_q.delete();
    expect_word(8'hA5);
    apb_write(2'd0, 16'h00A5, err);
    check("a5_pslverr", err, 1'b0);
    t0 = last_wr_cyc;
    wait_drain("a5", 400);
    check("a5_latency", first_rise() - t0, STROBE_POS + 1);
    check("a5_span", rise_span(), 7 * DIV);
`ifdef FIFO_TX_STATUS_EN
    apb_read(2'd2, rd, err);
    check("a5_status_underrun", rd, 16'h9000);
`endif
    apb_write(2'd1, 16'h0002, err);
`ifdef FIFO_TX_STATUS_EN
    apb_read(2'd2, rd, err);
    check("underrun_cleared", rd, 16'h1000);
`else
    apb_read(2'd2, rd, err);
    check("status_tied_zero", rd, 16'h0000);
`endif

    // Fill to 64 words, overflow write, then drain everything contiguously
    en_tx = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'((i * 37 + 5) & 8'hFF);
      apb_write(2'd0, {8'h00, w}, err);
      expect_word(w);
      if (i == AFULL_LEVEL - 2) check("afull_below", afull, 1'b0);
      if (i == AFULL_LEVEL - 1) check("afull_at", afull, 1'b1);
    end
    check("full_level", level, DEPTH);
    check("full_afull", afull, 1'b1);
    check("full_mem_state", mem_state, 1'b1);
    apb_write(2'd0, 16'h00EE, err);
    check("overflow_pslverr", err, 1'b1);
    check("overflow_level", level, DEPTH);
`ifdef FIFO_TX_STATUS_EN
    apb_read(2'd2, rd, err);
    check("full_status", rd, 16'h6040);
    check("status_read_pslverr", err, 1'b0);
`endif
    apb_write(2'd3, 16'h0000, err);
    check("addr3_write_pslverr", err, 1'b1);
    apb_read(2'd3, rd, err);
    check("addr3_read_pslverr", err, 1'b1);
    rise_q.delete();
    en_tx = 1'b1;
    wait_drain("fill", DEPTH * WIDTH * DIV + 200);
    check("fill_span", rise_span(), (DEPTH * WIDTH - 1) * DIV);
    check("fill_level", level, 0);
    check("fill_mem_state", mem_state, 1'b0);
    check("fill_afull", afull, 1'b0);

    // Two words back to back, then underrun
    en_tx = 1'b0;
    apb_write(2'd1, 16'h0002, err);
    apb_write(2'd0, 16'h0001, err);
    expect_word(8'h01);
    apb_write(2'd0, 16'h0080, err);
    expect_word(8'h80);
    rise_q.delete();
    @(posedge clk); #1;
    en_tx = 1'b1;
    wait_drain("b2b", 1000);
    check("b2b_count", rise_q.size(), 2 * WIDTH);
    check("b2b_span", rise_span(), (2 * WIDTH - 1) * DIV);
`ifdef FIFO_TX_STATUS_EN
    apb_read(2'd2, rd, err);
    check("b2b_underrun", rd, 16'h9000);
`endif

    // Flush during the first of three words
    en_tx = 1'b0;
    apb_write(2'd1, 16'h0002, err);
    apb_write(2'd0, 16'h0011, err);
    apb_write(2'd0, 16'h0022, err);
    apb_write(2'd0, 16'h0033, err);
    expect_word(8'h11);
    t0 = nrise;
    en_tx = 1'b1;
    wait_rises("flush", t0 + 2);
    apb_write(2'd1, 16'h0001, err);
    check("flush_pslverr", err, 1'b0);
    check("flush_level", level, 0);
    check("flush_mem_state", mem_state, 1'b0);
    wait_drain("flush", 400);
    wait_cycles(2 * WIDTH * DIV);
    check("flush_level_after", level, 0);

    // Drop en_tx mid-word, then re-raise it
    en_tx = 1'b0;
    apb_write(2'd1, 16'h0002, err);
    apb_write(2'd0, 16'h00FF, err);
    apb_write(2'd0, 16'h000F, err);
    expect_word(8'hFF);
    t0 = nrise;
    en_tx = 1'b1;
    wait_rises("drop", t0 + 4);
    en_tx = 1'b0;
    wait_drain("drop", 400);
    wait_cycles(WIDTH * DIV);
    check("drop_level", level, 1);
    check("drop_mem_state", mem_state, 1'b1);
    expect_word(8'h0F);
    rise_q.delete();
    t0 = cyc;
    en_tx = 1'b1;
    wait_drain("reraise", 400);
    check("reraise_latency", first_rise() - t0, STROBE_POS + 1);
    check("reraise_level", level, 0);

    // Reset in the middle of a word
    en_tx = 1'b0;
    apb_write(2'd0, 16'h00C3, err);
    apb_write(2'd0, 16'h0099, err);
    expect_word(8'hC3);
    t0 = nrise;
    en_tx = 1'b1;
    wait_rises("rstmid", t0 + 2);
    check("rstmid_level_before", level, 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_data_out", data_out, 1'b0);
    check("rstmid_iq_rate", iq_rate, 1'b0);
    check("rstmid_level", level, 0);
    check("rstmid_mem_state", mem_state, 1'b0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);
    check("rstmid_idle_data", data_out, 1'b0);
    rise_q.delete();
    expect_word(8'h3C);
    apb_write(2'd0, 16'h003C, err);
    t0 = last_wr_cyc;
    wait_drain("post_rst", 400);
    check("post_rst_latency", first_rise() - t0, STROBE_POS + 1);
    en_tx = 1'b0;
    wait_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_tx_serializer.md
# fifo_tx_serializer

Parametrised APB-fed transmit FIFO with a built-in serialiser for the Zigbee TX chain. The CPU pushes WIDTH-bit words over APB; the block emits them LSB-first as a bit stream at clk/DIV, with a bit-rate strobe for the I/Q modulator. Adds flush, almost-full, underrun detection and back-to-back words without gaps, and an optional APB status register.

## Interface
Parameters:
- WIDTH, 8, data word width (bits serialised per word)
- DEPTH, 64, FIFO depth in words; power of two, 2..2048
- DIV, 25, clk cycles per output bit (≥4); 50 MHz / 25 = 2 Mb/s
- STROBE_POS, 14, first div_cnt value of each bit period with iq_rate high (1..DIV-1)
- AFULL_LEVEL, 56, level at or above which afull asserts

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  2  word address: 0 DATA (W), 1 CTRL (W), 2 STATUS (R), 3 reserved
- pwdata  in  16  write data; DATA uses [WIDTH-1:0]
- prdata  out  16  read data
- pready  out  1  tied 1
- pslverr  out  1  APB error, valid in access phase
- en_tx  in  1  transmit enable from the TX controller
- data_out  out  1  serial bit
- iq_rate  out  1  bit-rate strobe
- mem_state  out  1  1 when FIFO not empty
- afull  out  1  level ≥ AFULL_LEVEL
- level  out  $clog2(DEPTH)+1  words stored

## Operation
- Access = psel & penable. Push = access & pwrite & paddr==0 & !full; pushes pwdata[WIDTH-1:0].
- CTRL write: bit0 flush (rd_ptr←wr_ptr, level←0), bit1 clears underrun; both self-clearing.
- pslverr=1 on DATA write while full (word dropped, no state change) and on any access to paddr 3; else 0.
- Pointers $clog2(DEPTH)+1 bits with wrap bit; full = same index, different wrap bit; empty = identical.
- Serialiser FSM, states IDLE, SHIFT:
  - IDLE: data_out=0, div_cnt=0. If en_tx & !empty: pop into shift register, bit_idx=0, →SHIFT.
  - SHIFT: data_out = shreg[bit_idx]; div_cnt counts 0..DIV-1; at DIV-1, bit_idx increments.
  - At div_cnt==DIV-1 & bit_idx==WIDTH-1: if en_tx & !empty, pop next word same cycle, stay SHIFT (no gap); else →IDLE.
  - en_tx deassert mid-word: current word completes, then IDLE.
  - Word end with en_tx=1 and FIFO empty: underrun sticky set, →IDLE.
- Simultaneous push and pop: both happen, level unchanged. Push into empty FIFO is poppable the following cycle.
- Flush while SHIFT: word already in shreg completes; later words discarded. Flush and push same cycle impossible (different paddr).

## Timing
- Reset: pointers, level, div_cnt, bit_idx, shreg, underrun = 0; state IDLE; data_out, iq_rate, pslverr, afull, mem_state = 0; prdata = 0.
- Pop latency: en_tx & !empty sampled at edge N → SHIFT at N+1, data_out = bit 0 from cycle N+1.
- Each bit held exactly DIV cycles; word = WIDTH*DIV cycles; consecutive words contiguous.
- iq_rate registered, high exactly on cycles where state==SHIFT and div_cnt ∈ [STROBE_POS, DIV-1]; 0 in IDLE.
- level, full, empty, afull, mem_state update the cycle after the push/pop/flush edge.
- Reset mid-word: immediate abort, all outputs to reset values asynchronously.

## Configuration
- FIFO_TX_STATUS_EN defined: read of paddr 2 returns prdata = {underrun, afull, full, empty, level zero-extended to 12 bits}; reads of paddr 0/1 return 0.
- Undefined: prdata tied 0, no read decode; underrun still tracked internally and clearable; pslverr rules unchanged.

## Test plan
- Reset, push 0xA5 with en_tx=1 → data_out LSB-first 1,0,1,0,0,1,0,1, each 25 cycles; iq_rate high on div_cnt 14..24; then IDLE, data_out=0.
- Push 64 words, 65th write → pslverr=1, level=64, afull=1; 65th word never transmitted.
- Push 0x01, 0x80, en_tx=1 → 16 contiguous bit periods (400 cycles), no idle cycle between words; then underrun=1 (STATUS bit15 with FIFO_TX_STATUS_EN).
- Push 3 words, start TX, CTRL write 0x1 during first word → first word completes, level=0, mem_state=0, remaining words not sent.
- Drop en_tx at bit 3 of 0xFF → all 8 bits sent, then IDLE; re-raise en_tx → next word starts one cycle later.
- Assert reset_n=0 mid-word → data_out, iq_rate, level, mem_state 0 immediately; after release, push 0x3C transmits normally.
